// File: rtl/seq_counter_n.sv
// rtl/seq_counter_n.sv - N-bit modulo up/down counter with step select, load, wrap/saturate and flags
module seq_counter_n #(
  parameter int WIDTH   = 4,
  parameter int MAX     = 9,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             x,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);
  localparam logic [WIDTH:0]   MAX_E = {1'b0, MAX_W};
  // MAX+1 always fits in WIDTH+1 bits since MAX <= 2**WIDTH-1
  localparam logic [WIDTH:0]   MOD_E = MAX_E + (WIDTH+1)'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0] cnt_e;
  logic [WIDTH:0] step_e;
  logic [WIDTH:0] up_sum;
  logic [WIDTH:0] up_wrap;
  logic [WIDTH:0] dn_diff;
  logic [WIDTH:0] dn_wrap;
  logic [WIDTH:0] ld_e;

  always_comb begin
    cnt_e   = {1'b0, count_q};
    step_e  = x ? (WIDTH+1)'(2) : (WIDTH+1)'(1);
    ld_e    = {1'b0, load_val};
    up_sum  = cnt_e + step_e;
    up_wrap = up_sum - MOD_E;
    dn_diff = cnt_e - step_e;
    dn_wrap = cnt_e + MOD_E - step_e;
  end

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q;
    if (load) begin
      count_d = (ld_e > MAX_E) ? MAX_W : load_val;
      ovf_d   = 1'b0;
    end else if (en) begin
      if (!dir) begin
        if (up_sum <= MAX_E) begin
          count_d = up_sum[WIDTH-1:0];
        end else if (sat_mode) begin
          count_d = MAX_W;
          ovf_d   = 1'b1;
        end else begin
          count_d = up_wrap[WIDTH-1:0];
          wrap_d  = 1'b1;
          ovf_d   = 1'b1;
        end
      end else begin
        if (cnt_e >= step_e) begin
          count_d = dn_diff[WIDTH-1:0];
        end else if (sat_mode) begin
          count_d = '0;
          ovf_d   = 1'b1;
        end else begin
          count_d = dn_wrap[WIDTH-1:0];
          wrap_d  = 1'b1;
          ovf_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= RST_W;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign ovf   = ovf_q;
  assign tc    = dir ? (count_q == '0) : (count_q == MAX_W);

endmodule

// File: doc/seq_counter_n.md
Name: seq_counter_n

Overview:
- Parametrised successor to the team's 2-bit input-steered sequence counter.
- N-bit modulo counter with:
  - programmable modulus top value
  - up/down direction
  - step-of-1 or step-of-2 advance, selected per cycle by input x
  - wrap or saturate mode
  - synchronous load and enable
  - terminal-count, wrap-pulse and sticky overflow flags
- Used as the generic sequencing/timing counter in controller datapaths, replacing hand-coded small-count FSMs.

Parameters:
- WIDTH, 4, counter width in bits (2..16).
- MAX, 9, highest count value; sequence is 0..MAX; 1 <= MAX <= 2**WIDTH-1.
- RST_VAL, 0, count value after reset; must be <= MAX.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  advance enable; count holds when low.
- load  in  1  synchronous load strobe, takes priority over en.
- load_val  in  WIDTH  value loaded when load=1.
- dir  in  1  0 = count up, 1 = count down.
- x  in  1  step select: 0 = step 1, 1 = step 2.
- sat_mode  in  1  0 = wrap modulo MAX+1, 1 = saturate at bound.
- count  out  WIDTH  registered count value.
- tc  out  1  terminal count, combinational from count/dir: (dir=0 and count==MAX) or (dir=1 and count==0).
- wrap  out  1  registered one-cycle pulse: the last advance crossed the bound.
- ovf  out  1  registered sticky flag: set on any wrap or saturation clip; cleared by reset or load.

Behaviour:
- Clock and reset: reset reset, asynchronous, active-high; clock clk. All state updates on the rising edge of clk.
- Reset values (immediately on reset assertion, independent of clk):
  - count = RST_VAL
  - wrap = 0
  - ovf = 0
  - tc follows count combinationally.
- Priority per edge: reset > load > en > hold.
- Load:
  - count <= min(load_val, MAX); a load_val above MAX clamps to MAX.
  - wrap <= 0, ovf <= 0.
  - dir, x and sat_mode are ignored in that cycle.
- Hold (en=0, load=0): count unchanged; wrap <= 0; ovf unchanged.
- Advance (en=1, load=0): step s = 1 + x.
  - All arithmetic in WIDTH+1 bits; no intermediate truncation.
- Advance up (dir=0):
  - count+s <= MAX: count <= count+s; wrap <= 0.
  - Over the bound, wrap mode: count <= count+s-(MAX+1); wrap <= 1; ovf <= 1.
  - Over the bound, saturate mode: count <= MAX; wrap <= 0; ovf <= 1.
  - Example, MAX=9, count=9, x=1, wrap mode -> count=1.
- Advance down (dir=1):
  - count >= s: count <= count-s; wrap <= 0.
  - Below zero, wrap mode: count <= count+(MAX+1)-s; wrap <= 1; ovf <= 1.
  - Below zero, saturate mode: count <= 0; wrap <= 0; ovf <= 1.
- Saturate while already at the bound (e.g. count=MAX, up, sat_mode=1): count stays, ovf <= 1, wrap stays 0.
- MAX=1 with step 2 in wrap mode lands on the same value (count+2-2); wrap <= 1.
- dir, x and sat_mode may change every cycle; each edge uses the values sampled at that edge.
- Reset asserted mid-sequence: immediate return to RST_VAL and all flags clear. After deassertion, the first edge applies the normal priority rules.
- tc has zero latency relative to count. wrap and ovf reflect the advance performed at the most recent edge.

Test Plan:
- Reset: WIDTH=4, MAX=9, RST_VAL=0; reset=1 for 2 edges, then en=1, x=0, dir=0 for 10 edges -> count 1,2,..,9,0. On the edge 9->0: wrap=1 for one cycle, ovf=1. tc=1 while count=9.
- Step 2 wrap up: load 8, then en=1, x=1, dir=0 -> count 0 (wrap=1), then 2, then 4; ovf stays 1 until the next load.
- Down saturate: load 3, dir=1, x=1, sat_mode=1, en=1 -> count 1, then 0 (ovf=1, wrap=0), then 0 held; tc=1 at 0.
- Down wrap: load 1, dir=1, x=1, sat_mode=0 -> count 9 (1+10-2), wrap=1; next edge -> 7, wrap=0.
- Load and enable interaction: load_val=15 with load=1, en=1 -> count=9 (clamped), ovf=0. With en=0 and toggling x/dir, count holds 9 and wrap=0.
- Async reset mid-count: count=6, assert reset between edges -> count=0, ovf=0 immediately with no clock edge. Deassert; next en edge -> count=1.
